// File: rtl/traffic_light_monitor.sv
// Passive safety checker on the four lamp buses: code legality, R->G->Y->R order, dwell limits, conflicts, all-red stall.
// Zero latency (a violation sampled at an edge is flagged on that edge), flags sticky until clr/rst; purely passive, no backpressure.
module traffic_light_monitor #(
  parameter int CW         = 8,
  parameter int YEL_MIN    = 2,
  parameter int YEL_MAX    = 5,
  parameter int GRN_MAX    = 15,
  parameter int ALLRED_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_S,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_M2,
  input  logic       clr,
  output logic       fault_conflict,
  output logic       fault_code,
  output logic       fault_seq,
  output logic       fault_timing,
  output logic       fault_stall,
  output logic       fault_any,
  output logic [2:0] first_type,
  output logic [1:0] first_app
);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [1:0] {RED = 2'd0, GRN = 2'd1, YEL = 2'd2} state_t;

  logic [3:0][2:0] lamp;
  state_t          st_q [4];
  state_t          st_d [4];
  state_t          code_st [4];
  logic [CW-1:0]   dwell_q [4];
  logic [CW-1:0]   dwell_d [4];
  logic [CW-1:0]   allred_q, allred_d;
  logic [3:0]      legal, act, seq_err, tim_err;
  logic            all_red, stall_err;
  logic            conf_m1_s, conf_s_m, conf_mt_m2, conf_err;
  logic [1:0]      conf_app;
  logic [4:0]      flags_q, flags_d, new_flags;  // {stall, timing, seq, code, conflict}
  logic [2:0]      new_type, first_type_d;
  logic [1:0]      new_app, first_app_d;

  assign lamp = {light_M2, light_MT, light_S, light_M1};

  function automatic logic [1:0] lowest(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) idx = 2'(i);
    return idx;
  endfunction

  // Per-approach FSM and dwell counter; an illegal code freezes both and skips the order check.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      legal[i]   = (lamp[i] == LAMP_R) || (lamp[i] == LAMP_Y) || (lamp[i] == LAMP_G);
      code_st[i] = (lamp[i] == LAMP_G) ? GRN : (lamp[i] == LAMP_Y) ? YEL : RED;
      act[i]     = legal[i] && (code_st[i] != RED);
      st_d[i]    = st_q[i];
      dwell_d[i] = dwell_q[i];
      seq_err[i] = 1'b0;
      tim_err[i] = 1'b0;
      if (legal[i]) begin
        st_d[i] = code_st[i];
        if (code_st[i] != st_q[i])     dwell_d[i] = CW'(1);
        else if (dwell_q[i] != '1)     dwell_d[i] = dwell_q[i] + CW'(1);
        unique case (st_q[i])
          RED: seq_err[i] = (code_st[i] == YEL);
          GRN: begin
            seq_err[i] = (code_st[i] == RED);
            tim_err[i] = (code_st[i] == GRN) && (dwell_q[i] == CW'(GRN_MAX));
          end
          YEL: begin
            seq_err[i] = (code_st[i] == GRN);
            tim_err[i] = ((code_st[i] == YEL) && (dwell_q[i] == CW'(YEL_MAX))) ||
                         ((code_st[i] == RED) && (dwell_q[i] < CW'(YEL_MIN)));
          end
          default: seq_err[i] = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    all_red    = (lamp[0] == LAMP_R) && (lamp[1] == LAMP_R) &&
                 (lamp[2] == LAMP_R) && (lamp[3] == LAMP_R);
    allred_d   = all_red ? ((allred_q == '1) ? allred_q : allred_q + CW'(1)) : '0;
    stall_err  = all_red && (allred_q == CW'(ALLRED_MAX));

    // M1+M2 and M1+MT are permitted pairs; a conflict reports the lower index of the pair.
    conf_m1_s  = act[0] && act[1];
    conf_s_m   = act[1] && (act[2] || act[3]);
    conf_mt_m2 = act[2] && act[3];
    conf_err   = conf_m1_s || conf_s_m || conf_mt_m2;
    conf_app   = conf_m1_s ? 2'd0 : conf_s_m ? 2'd1 : 2'd2;

    new_flags  = {stall_err, |tim_err, |seq_err, |(~legal), conf_err};
    new_type   = 3'd0;
    new_app    = 2'd0;
    if (conf_err) begin
      new_type = 3'd1;
      new_app  = conf_app;
    end else if (|(~legal)) begin
      new_type = 3'd2;
      new_app  = lowest(~legal);
    end else if (|seq_err) begin
      new_type = 3'd3;
      new_app  = lowest(seq_err);
    end else if (|tim_err) begin
      new_type = 3'd4;
      new_app  = lowest(tim_err);
    end else if (stall_err) begin
      new_type = 3'd5;
    end

    flags_d      = (clr ? 5'd0 : flags_q) | new_flags;
    first_type_d = clr ? 3'd0 : first_type;
    first_app_d  = clr ? 2'd0 : first_app;
    if ((clr || (first_type == 3'd0)) && (new_type != 3'd0)) begin
      first_type_d = new_type;
      first_app_d  = new_app;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]    <= RED;
        dwell_q[i] <= '0;
      end
      allred_q   <= '0;
      flags_q    <= '0;
      first_type <= '0;
      first_app  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]    <= st_d[i];
        dwell_q[i] <= dwell_d[i];
      end
      allred_q   <= allred_d;
      flags_q    <= flags_d;
      first_type <= first_type_d;
      first_app  <= first_app_d;
    end
  end

  assign {fault_stall, fault_timing, fault_seq, fault_code, fault_conflict} = flags_q;
  assign fault_any = |flags_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: the driver queues hand-computed expected outputs per cycle,
// a monitor pops and compares one entry after every rising edge.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  localparam logic [4:0] F_CONF  = 5'b00001;
  localparam logic [4:0] F_CODE  = 5'b00010;
  localparam logic [4:0] F_SEQ   = 5'b00100;
  localparam logic [4:0] F_TIM   = 5'b01000;
  localparam logic [4:0] F_STALL = 5'b10000;

  typedef struct packed {
    logic [4:0] flags;  // {stall, timing, seq, code, conflict}
    logic       any;
    logic [2:0] ftype;
    logic [1:0] fapp;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] light_M1, light_S, light_MT, light_M2;
  logic       clr;
  logic       fault_conflict, fault_code, fault_seq, fault_timing, fault_stall, fault_any;
  logic [2:0] first_type;
  logic [1:0] first_app;

  exp_t  exp_q [$];
  string name_q [$];
  int    checks = 0;
  int    errors = 0;

  logic [4:0] e_flags;
  logic [2:0] e_type;
  logic [1:0] e_app;
  int         p;
  logic [2:0] v_m1, v_s;

  traffic_light_monitor dut (
    .clk            (clk),
    .rst            (rst),
    .light_M1       (light_M1),
    .light_S        (light_S),
    .light_MT       (light_MT),
    .light_M2       (light_M2),
    .clr            (clr),
    .fault_conflict (fault_conflict),
    .fault_code     (fault_code),
    .fault_seq      (fault_seq),
    .fault_timing   (fault_timing),
    .fault_stall    (fault_stall),
    .fault_any      (fault_any),
    .first_type     (first_type),
    .first_app      (first_app)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One queued expectation per driven cycle, so driver and monitor stay aligned edge for edge.
  task automatic step(input logic [2:0] m1, input logic [2:0] s, input logic [2:0] mt,
                      input logic [2:0] m2, input logic c, input logic r, input string nm);
    exp_t e;
    @(negedge clk);
    light_M1 = m1;
    light_S  = s;
    light_MT = mt;
    light_M2 = m2;
    clr      = c;
    rst      = r;
    if (r) begin
      e_flags = 5'd0;
      e_type  = 3'd0;
      e_app   = 2'd0;
    end
    e.flags = e_flags;
    e.any   = |e_flags;
    e.ftype = e_type;
    e.fapp  = e_app;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic expect_state(input logic [4:0] f, input logic [2:0] t, input logic [1:0] a);
    e_flags = f;
    e_type  = t;
    e_app   = a;
  endtask

  always @(posedge clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {fault_stall, fault_timing, fault_seq, fault_code, fault_conflict,
            fault_any, first_type, first_app};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got flags=%b any=%b type=%0d app=%0d, want flags=%b any=%b type=%0d app=%0d",
                 nm, a.flags, a.any, a.ftype, a.fapp, e.flags, e.any, e.ftype, e.fapp);
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0;
    light_M1 = R; light_S = R; light_MT = R; light_M2 = R;
    expect_state(5'd0, 3'd0, 2'd0);

    // Reset state, then a legal alternating M1 / S cycle for 100 cycles.
    step(R, R, R, R, 0, 1, "reset");
    step(R, R, R, R, 0, 1, "reset_hold");
    for (int k = 0; k < 100; k++) begin
      p = k % 20;
      if (p < 7)       begin v_m1 = G; v_s = R; end
      else if (p < 10) begin v_m1 = Y; v_s = R; end
      else if (p < 17) begin v_m1 = R; v_s = G; end
      else             begin v_m1 = R; v_s = Y; end
      step(v_m1, v_s, R, R, 0, 0, "legal_cycle");
    end

    // M1 green 3 cycles then straight to red; clr afterwards.
    step(R, R, R, R, 0, 1, "reset");
    step(G, R, R, R, 0, 0, "seq_green1");
    step(G, R, R, R, 0, 0, "seq_green2");
    step(G, R, R, R, 0, 0, "seq_green3");
    expect_state(F_SEQ, 3'd3, 2'd0);
    step(R, R, R, R, 0, 0, "seq_g_to_r");
    step(R, R, R, R, 0, 0, "seq_sticky");
    expect_state(5'd0, 3'd0, 2'd0);
    step(R, R, R, R, 1, 0, "seq_clr");
    step(R, R, R, R, 0, 0, "seq_after_clr");

    // S green while MT yellow.
    step(R, R, R, R, 0, 1, "reset");
    step(R, R, G, R, 0, 0, "conf_mt_green");
    step(R, R, Y, R, 0, 0, "conf_mt_yellow");
    expect_state(F_CONF, 3'd1, 2'd1);
    step(R, G, Y, R, 0, 0, "conf_s_vs_mt");

    // M1 and M2 green together is permitted.
    step(R, R, R, R, 0, 1, "reset");
    step(G, R, R, G, 0, 0, "m1_m2_ok1");
    step(G, R, R, G, 0, 0, "m1_m2_ok2");

    // Illegal code on M2, then green from the held RED state.
    step(R, R, R, R, 0, 1, "reset");
    expect_state(F_CODE, 3'd2, 2'd3);
    step(R, R, R, 3'b111, 0, 0, "code_illegal");
    step(R, R, R, G, 0, 0, "code_then_green");
    step(R, R, R, G, 0, 0, "code_green_hold");

    // Yellow held 6 cycles: timing fault on the 6th.
    step(R, R, R, R, 0, 1, "reset");
    step(G, R, R, R, 0, 0, "ylong_green");
    for (int k = 0; k < 5; k++) step(Y, R, R, R, 0, 0, "ylong_within");
    expect_state(F_TIM, 3'd4, 2'd0);
    step(Y, R, R, R, 0, 0, "ylong_6th");
    step(Y, R, R, R, 0, 0, "ylong_7th");
    step(R, R, R, R, 0, 0, "ylong_to_red");

    // Yellow for only one cycle then red.
    step(R, R, R, R, 0, 1, "reset");
    step(G, R, R, R, 0, 0, "yshort_green");
    step(Y, R, R, R, 0, 0, "yshort_yellow");
    expect_state(F_TIM, 3'd4, 2'd0);
    step(R, R, R, R, 0, 0, "yshort_to_red");

    // All-red held: stall on the 5th sample.
    step(R, R, R, R, 0, 1, "reset");
    for (int k = 0; k < 4; k++) step(R, R, R, R, 0, 0, "allred_within");
    expect_state(F_STALL, 3'd5, 2'd0);
    step(R, R, R, R, 0, 0, "allred_5th");
    step(R, R, R, R, 0, 0, "allred_6th");

    // clr together with a new M1/S conflict: conflict wins and reloads the capture.
    expect_state(F_CONF, 3'd1, 2'd0);
    step(G, G, R, R, 1, 0, "clr_with_conflict");
    step(Y, Y, R, R, 0, 0, "conflict_no_reload");

    // Reset mid-yellow clears everything; next yellow is checked against RED.
    step(Y, Y, R, R, 0, 1, "reset_mid_yellow");
    expect_state(F_SEQ, 3'd3, 2'd0);
    step(Y, R, R, R, 0, 0, "post_reset_r_to_y");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, want completion");
    $fatal(1);
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive safety checker on the four lamp buses driven by Traffic_Light_Controller: light_M1, light_S, light_MT and light_M2.
- Samples the buses every clk edge and checks four things: encoding legality, the per-approach R->G->Y->R sequence, dwell-time limits and cross-approach conflicts.
- Raises sticky fault flags and captures the first fault, for use by a failsafe flasher or a debug register.
- Counts are in clk cycles; clk is 1 Hz, so one cycle is one second.

Parameters:
- CW, 8, width of the per-approach dwell counters and the all-red counter. All counters saturate at 2^CW-1.
- YEL_MIN, 2, minimum number of consecutive yellow cycles before a legal Y->R transition.
- YEL_MAX, 5, maximum number of consecutive yellow cycles.
- GRN_MAX, 15, maximum number of consecutive green cycles.
- ALLRED_MAX, 4, maximum number of consecutive all-red cycles before a stall fault.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- light_M1, input, 3, main road approach 1 lamp code.
- light_S, input, 3, side road lamp code.
- light_MT, input, 3, main road turn lamp code.
- light_M2, input, 3, main road approach 2 lamp code.
- clr, input, 1, synchronous clear of the sticky flags and the first-fault capture.
- fault_conflict, output, 1, sticky: conflicting approaches were non-red.
- fault_code, output, 1, sticky: an illegal lamp code was seen.
- fault_seq, output, 1, sticky: an illegal transition was seen.
- fault_timing, output, 1, sticky: a dwell limit was violated.
- fault_stall, output, 1, sticky: all-red lasted too long.
- fault_any, output, 1, OR of the five sticky flags.
- first_type, output, 3, type of the first fault: 0 none, 1 conflict, 2 code, 3 seq, 4 timing, 5 stall.
- first_app, output, 2, approach of the first fault: M1=0, S=1, MT=2, M2=3.

Behaviour:
- Lamp encoding: 3'b100 red, 3'b010 yellow, 3'b001 green. Every other value (000, 011, 111, ...) is illegal.
- Reset (rst=1 at a clk edge):
  - All flag outputs and first_type/first_app go to 0.
  - All dwell and all-red counters go to 0.
  - Each approach's last-legal-state register goes to RED.
  - No checks are made during reset.
- Latency: a violation present on the inputs at edge n sets its flag on edge n, so the flag is visible from edge n until cleared.
- Per approach, one small FSM with states RED, GRN, YEL:
  - State = last legal sampled code.
  - Legal moves: stay, R->G, G->Y, Y->R.
  - G->R, Y->G and R->Y set fault_seq. The FSM still follows the input.
- Illegal code:
  - Sets fault_code.
  - FSM state and dwell counter hold.
  - The sequence check is skipped for that sample.
  - The next legal sample is checked against the held state.
- Dwell counter:
  - Reloads to 1 on a state change; increments while the state is unchanged.
  - Timing faults:
    - Entering the yellow sample where the count would reach YEL_MAX+1.
    - The green sample where the count would reach GRN_MAX+1.
    - A Y->R transition where the yellow count was < YEL_MIN.
  - Each limit reports once per dwell episode. The counter saturates.
- Conflicts: fault_conflict is evaluated on legal codes only; "active" means green or yellow.
  - S active while any of M1, M2 or MT is active.
  - M2 active while MT is active.
  - The pairs M1+M2 and M1+MT are permitted.
- Stall:
  - The all-red counter increments while all four inputs are 3'b100 and clears otherwise.
  - fault_stall sets when the count reaches ALLRED_MAX+1.
- First-fault capture:
  - Loads only when first_type==0.
  - Priority for simultaneous faults: conflict > code > seq > timing > stall; within a type, the lowest approach index wins.
  - Conflict reports the lower index of the pair. Stall reports app 0.
- clr:
  - Zeroes the flags and the capture. It does not touch the FSMs or counters.
  - A violation in the same cycle as clr wins: its flag is set and the capture reloads.
- Reset mid-episode discards all history; the first sample after reset is checked against RED.

Test Plan:
- Legal cycle: M1=G for 7 cycles, Y for 3, R; S follows R->G(7)->Y(3)->R, with no overlap. Required: all flags stay 0 for 100 cycles.
- Sequence fault: M1 goes G (3 cycles) then directly 3'b100. Required: fault_seq=1 on that edge, first_type=3, first_app=0. Then pulse clr: flags return to 0.
- Conflict: S=3'b001 while MT=3'b010. Required: fault_conflict=1, first_type=1, first_app=1. M1=G together with M2=G alone must give no flag.
- Illegal code: light_M2=3'b111 for one cycle, then 3'b001 from a held RED state. Required: fault_code=1, no fault_seq, first_app=3.
- Timing and stall:
  - Yellow held 6 cycles: fault_timing on the 6th.
  - Yellow held 1 cycle then R: fault_timing at the Y->R edge.
  - All-red held 5 cycles: fault_stall on the 5th.
- Simultaneous events: clr asserted in the same cycle as a new conflict. Required: fault_conflict=1 and first_type=1 after the edge. Also assert rst mid-yellow and check every output reads 0 on the next edge.
